// File: rtl/expr_stream_arbiter.sv
// Round-robin arbiter that shares one expression recognizer among N_REQ character streams.
// Each granted string is checked against digit (('+'|'*') digit)* and yields one tagged verdict.
module expr_stream_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  output logic [2:0]         res_id,
  output logic               res_ok,
  output logic [7:0]         res_len,
  output logic               busy
);

  localparam int unsigned MAXL = MAX_LEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;
  typedef enum logic [1:0] {R_START, R_NUM, R_OP, R_ERR} rec_t;

  state_t      state, state_n;
  rec_t        rec, rec_n;
  logic [2:0]  g, g_n, rr, rr_n;
  logic [7:0]  len, len_n;
  logic [2:0]  pick_hi, pick_lo;
  logic        found_hi, found_lo;
  logic [7:0]  ch;
  logic        valid_g, last_g, hs;

  function automatic rec_t rec_step(input rec_t r, input logic [7:0] c);
    logic dig, op;
    dig = (c >= 8'h30) && (c <= 8'h39);
    op  = (c == 8'h2B) || (c == 8'h2A);
    case (r)
      R_START: return dig ? R_NUM : R_ERR;
      R_NUM:   return op  ? R_OP  : R_ERR;
      R_OP:    return dig ? R_NUM : R_ERR;
      default: return R_ERR;
    endcase
  endfunction

  // Rotating priority: first valid at or after rr, else first valid from index 0.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = 3'(i);
      end
      if (req_valid[i] && !found_hi && (i >= 32'(rr))) begin
        found_hi = 1'b1;
        pick_hi  = 3'(i);
      end
    end
  end

  always_comb begin
    ch      = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (3'(i) == g) begin
        ch      = req_char[8*i +: 8];
        valid_g = req_valid[i];
        last_g  = req_last[i];
      end
    end
  end

  assign hs = (state == S_RUN) && valid_g;

  always_comb begin
    state_n = state;
    g_n     = g;
    rr_n    = rr;
    rec_n   = rec;
    len_n   = len;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          g_n     = found_hi ? pick_hi : pick_lo;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          rec_n = rec_step(rec, ch);
          len_n = (len == 8'hFF) ? len : len + 8'd1;
          if (last_g) state_n = S_REPORT;
        end
      end
      S_REPORT: begin
        rr_n    = (g == 3'(N_REQ - 1)) ? '0 : g + 3'd1;
        rec_n   = R_START;
        len_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      g     <= '0;
      rr    <= '0;
      rec   <= R_START;
      len   <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      rr    <= rr_n;
      rec   <= rec_n;
      len   <= len_n;
    end
  end

  // Outputs decode registered state only, so ready never depends on req_valid.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state == S_RUN) && (3'(i) == g);
    end
    res_valid = (state == S_REPORT);
    res_id    = res_valid ? g : '0;
    res_len   = res_valid ? len : '0;
    res_ok    = res_valid && (rec == R_NUM) && (32'(len) <= MAXL);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_expr_stream_arbiter.sv
// Directed bench for expr_stream_arbiter: grammar verdicts, round-robin order, stalls, length limits, reset.
module tb_expr_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_char;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [2:0]  res_id;
  logic        res_ok;
  logic [7:0]  res_len;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  expr_stream_arbiter #(.N_REQ(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_char(req_char), .req_last(req_last), .req_ready(req_ready),
    .res_valid(res_valid), .res_id(res_id), .res_ok(res_ok), .res_len(res_len), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: got no finish, want finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; req_char = '0; req_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams a whole string on one port; returns grant latency and the verdict seen after the last handshake.
  task automatic send_string(input logic [1:0] p, input string s, output int lat,
                             output logic rv, output logic [2:0] rid, output logic rok,
                             output logic [7:0] rlen);
    int i = 0;
    int cyc = 0;
    lat = -1;
    while (i < s.len() && cyc < 1000) begin
      req_valid[p] = 1'b1;
      req_char[{p, 3'b000} +: 8] = s[i];
      req_last[p] = (i == s.len() - 1);
      if (req_ready[p]) begin
        if (lat < 0) lat = cyc;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid[p] = 1'b0;
    req_last[p]  = 1'b0;
    rv   = (i == s.len()) ? res_valid : 1'b0;
    rid  = res_id;
    rok  = res_ok;
    rlen = res_len;
  endtask

  task automatic offer(input logic [1:0] p, input logic [7:0] c, input logic l);
    int cyc = 0;
    req_valid[p] = 1'b1;
    req_char[{p, 3'b000} +: 8] = c;
    req_last[p] = l;
    while (!req_ready[p] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (req_ready[p] !== 1'b1) begin
      n_fail++;
      $display("FAIL offer_ready port=%0d got %b want 1", p, req_ready[p]);
    end
    @(negedge clk);
    req_valid[p] = 1'b0;
    req_last[p]  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({req_ready, res_valid, res_id, res_ok, res_len, busy} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ready=%b rv=%b id=%0d ok=%b len=%0d busy=%b want all 0",
               req_ready, res_valid, res_id, res_ok, res_len, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, res_valid, busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_outputs got ready=%b rv=%b busy=%b want 0", req_ready, res_valid, busy);
    end
  endtask

  task automatic test_basic();
    int lat; logic rv, rok; logic [2:0] rid; logic [7:0] rlen;
    send_string(2'd0, "1+2*3", lat, rv, rid, rok, rlen);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL basic_latency got %0d want 1", lat); end
    n_tests++;
    if ({rv, rid, rok, rlen} !== {1'b1, 3'd0, 1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL basic_result got rv=%b id=%0d ok=%b len=%0d want 1/0/1/5", rv, rid, rok, rlen);
    end
    @(negedge clk);
    n_tests++;
    if ({res_valid, res_len} !== 9'd0) begin
      n_fail++;
      $display("FAIL basic_strobe got rv=%b len=%0d want 0/0", res_valid, res_len);
    end
  endtask

  task automatic test_malformed();
    string mal[4] = '{"1++2", "12", "+3", "4+"};
    logic [7:0] mlen[4] = '{8'd4, 8'd2, 8'd2, 8'd2};
    int lat; logic rv, rok; logic [2:0] rid; logic [7:0] rlen;
    for (int k = 0; k < 4; k++) begin
      send_string(2'd1, mal[k], lat, rv, rid, rok, rlen);
      n_tests++;
      if ({rv, rid, rok, rlen} !== {1'b1, 3'd1, 1'b0, mlen[k]}) begin
        n_fail++;
        $display("FAIL malformed_%0d got rv=%b id=%0d ok=%b len=%0d want 1/1/0/%0d",
                 k, rv, rid, rok, rlen, mlen[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want_id[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    int nres = 0;
    int cyc = 0;
    int multi = 0;
    do_reset();
    req_valid = 4'hF;
    req_char  = {4{8'h37}};
    req_last  = 4'hF;
    while (nres < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if ($countones(req_ready) > 1) multi++;
      if (res_valid) begin
        n_tests++;
        if ({res_id, res_ok, res_len} !== {want_id[nres], 1'b1, 8'd1}) begin
          n_fail++;
          $display("FAIL rr_result_%0d got id=%0d ok=%b len=%0d want %0d/1/1",
                   nres, res_id, res_ok, res_len, want_id[nres]);
        end
        nres++;
      end
    end
    req_valid = '0; req_last = '0;
    n_tests++;
    if (nres !== 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", nres); end
    n_tests++;
    if (multi !== 0) begin n_fail++; $display("FAIL rr_onehot got %0d multi-hot cycles want 0", multi); end
  endtask

  task automatic test_stall();
    int cyc = 0;
    do_reset();
    req_valid[3] = 1'b1; req_char[31:24] = "5"; req_last[3] = 1'b1;
    offer(2'd2, "9", 1'b0);
    offer(2'd2, "*", 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({req_ready, busy, res_valid} !== {4'b0100, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got ready=%b busy=%b rv=%b want 0100/1/0",
                 k, req_ready, busy, res_valid);
      end
      @(negedge clk);
    end
    offer(2'd2, "8", 1'b1);
    n_tests++;
    if ({res_valid, res_id, res_ok, res_len} !== {1'b1, 3'd2, 1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL stall_result got rv=%b id=%0d ok=%b len=%0d want 1/2/1/3",
               res_valid, res_id, res_ok, res_len);
    end
    @(negedge clk);
    while (!res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if ({res_valid, res_id, res_ok, res_len} !== {1'b1, 3'd3, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL stall_next got rv=%b id=%0d ok=%b len=%0d want 1/3/1/1",
               res_valid, res_id, res_ok, res_len);
    end
    req_valid[3] = 1'b0; req_last[3] = 1'b0;
  endtask

  task automatic test_length();
    string longs = "";
    int lat; logic rv, rok; logic [2:0] rid; logic [7:0] rlen;
    send_string(2'd0, "1+1+1+1+1+1+1+1+1", lat, rv, rid, rok, rlen);
    n_tests++;
    if ({rv, rok, rlen} !== {1'b1, 1'b0, 8'd17}) begin
      n_fail++;
      $display("FAIL len17 got rv=%b ok=%b len=%0d want 1/0/17", rv, rok, rlen);
    end
    send_string(2'd0, "1+1+1+1+1+1+1+1", lat, rv, rid, rok, rlen);
    n_tests++;
    if ({rv, rok, rlen} !== {1'b1, 1'b1, 8'd15}) begin
      n_fail++;
      $display("FAIL len15 got rv=%b ok=%b len=%0d want 1/1/15", rv, rok, rlen);
    end
    for (int k = 0; k < 150; k++) longs = {longs, "1+"};
    send_string(2'd0, longs, lat, rv, rid, rok, rlen);
    n_tests++;
    if ({rv, rok, rlen} !== {1'b1, 1'b0, 8'd255}) begin
      n_fail++;
      $display("FAIL len_saturate got rv=%b ok=%b len=%0d want 1/0/255", rv, rok, rlen);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat; logic rv, rok; logic [2:0] rid; logic [7:0] rlen;
    do_reset();
    offer(2'd1, "5", 1'b0);
    offer(2'd1, "+", 1'b0);
    offer(2'd1, "6", 1'b0);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, res_valid, res_id, res_ok, res_len, busy} !== 18'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got ready=%b rv=%b len=%0d busy=%b want all 0",
               req_ready, res_valid, res_len, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_verdict got %0d verdicts want 0", seen); end
    send_string(2'd1, "5+6*7", lat, rv, rid, rok, rlen);
    n_tests++;
    if ({rv, rid, rok, rlen} !== {1'b1, 3'd1, 1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL midrst_resend got rv=%b id=%0d ok=%b len=%0d want 1/1/1/5", rv, rid, rok, rlen);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_char = '0; req_last = '0;
    test_reset();
    test_basic();
    test_malformed();
    test_round_robin();
    test_stall();
    test_length();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
